// File: rtl/seq_ctrl_pkg.sv
// Shared types and width helpers for the programmable serial sequence matcher.
//   state_t : controller state (IDLE, RUN, DONE)
//   len_w   : bits needed to hold a pattern length 0..max_len
//   fill_w  : bits needed to hold the history fill level 0..max_len
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int fill_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_match_controller_if.sv
// Control/status bundle between a CSR master and the sequence matcher.
//   master : drives configuration offer, start and abort; observes status
//   slave  : the controller side (cfg_ready and all status outputs)
interface seq_match_controller_if
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
);
  localparam int LEN_W = len_w(MAX_LEN);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic [TMO_W-1:0]   cfg_timeout;
  logic               start;
  logic               abort;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;
  logic               timed_out;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_timeout, start, abort,
    input  cfg_ready, detected, match_count, busy, done, timed_out, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_timeout, start, abort,
    output cfg_ready, detected, match_count, busy, done, timed_out, cfg_err
  );

endinterface

// File: rtl/seq_shift_matcher.sv
// Shift-register history of the serial input plus a fill counter.
//   clr      : clear history and fill (takes priority over shift_en)
//   shift_en : sample a into the history on this edge
//   pattern  : [len-1] is the oldest bit, [0] the newest
//   len      : active pattern length
//   match    : combinational; high when the bit being shifted in completes the pattern
module seq_shift_matcher
  import seq_ctrl_pkg::*;
#(
  parameter int  MAX_LEN = 8,
  localparam int LEN_W   = len_w(MAX_LEN),
  localparam int FILL_W  = fill_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               a,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [FILL_W-1:0]  fill;
  logic               mismatch;
  logic               enough;

  assign hist_next = {hist[MAX_LEN-2:0], a};

  // NOTE: the history is a handful of flops, not a RAM, so it is reset like any other state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_next;
      if (fill != FILL_W'(MAX_LEN)) fill <= fill + FILL_W'(1);
    end
  end

  // Compare only the low len bits of the history as it will be after this edge.
  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len) && (hist_next[i] != pattern[i])) mismatch = 1'b1;
    end
  end

  // One extra bit so fill+1 cannot wrap.
  assign enough = ({1'b0, fill} + (FILL_W + 1)'(1)) >= (FILL_W + 1)'(len);
  assign match  = shift_en && enough && !mismatch;

endmodule

// File: rtl/seq_match_controller.sv
// Programmable serial bit-pattern detector with target count, timeout and abort.
//   clk, rst : single clock, synchronous active-high reset
//   a        : serial input bit, sampled on every RUN edge
//   bus      : configuration handshake, start/abort and status outputs
module seq_match_controller
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a,
  seq_match_controller_if.slave  bus
);
  localparam int LEN_W = len_w(MAX_LEN);

  state_t             state, state_next;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   target_q;
  logic [TMO_W-1:0]   timeout_q;
  logic               cfg_loaded;
  logic               cfg_err_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_inc;
  logic [TMO_W-1:0]   timer_q;
  logic               det_q;
  logic               tmo_q;
  logic               cfg_xfer;
  logic               start_go;
  logic               run_edge;
  logic               match;
  logic               target_hit;
  logic               tmo_hit;

  assign cfg_xfer = bus.cfg_valid && bus.cfg_ready;
  // Abort wins over start in every state.
  assign start_go = bus.start && !bus.abort &&
                    (((state == IDLE) && cfg_loaded && !cfg_err_q) || (state == DONE));
  assign run_edge = (state == RUN) && !bus.abort;

  assign count_inc  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
  assign target_hit = match && (target_q != '0) && (count_inc == target_q);
  // A match restarts the timer, so timeout is only considered on non-matching edges.
  assign tmo_hit    = run_edge && !match && (timeout_q != '0) &&
                      (timer_q == timeout_q - TMO_W'(1));

  seq_shift_matcher #(.MAX_LEN(MAX_LEN)) u_matcher (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_go),
    .shift_en (run_edge),
    .a        (a),
    .pattern  (pattern_q),
    .len      (len_q),
    .match    (match)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_go) state_next = RUN;
      RUN: begin
        if (bus.abort)                  state_next = IDLE;
        else if (target_hit || tmo_hit) state_next = DONE;
      end
      DONE: begin
        if (bus.abort)     state_next = IDLE;
        else if (start_go) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q  <= '0;
      len_q      <= '0;
      target_q   <= '0;
      timeout_q  <= '0;
      cfg_loaded <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else if (cfg_xfer) begin
      pattern_q  <= bus.cfg_pattern;
      len_q      <= bus.cfg_len;
      target_q   <= bus.cfg_target;
      timeout_q  <= bus.cfg_timeout;
      cfg_loaded <= 1'b1;
      cfg_err_q  <= (bus.cfg_len == '0) || (bus.cfg_len > LEN_W'(MAX_LEN));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_q   <= 1'b0;
      count_q <= '0;
      timer_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      det_q <= match;
      if (start_go) begin
        count_q <= '0;
        timer_q <= '0;
        tmo_q   <= 1'b0;
      end else if (run_edge) begin
        if (match) begin
          count_q <= count_inc;
          timer_q <= '0;
        end else begin
          timer_q <= timer_q + TMO_W'(1);
          if (tmo_hit) tmo_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cfg_ready   = (state == IDLE);
  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.detected    = det_q;
  assign bus.match_count = count_q;
  assign bus.timed_out   = tmo_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_match_controller.sv
// Self-checking bench for seq_match_controller: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_seq_match_controller;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int TMO_W   = 16;

  logic clk = 1'b0;
  logic rst;
  logic a;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_match_controller_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

  seq_match_controller #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit       m_busy, m_done, m_det, m_tmo, m_err, m_loaded;
  int       m_count, m_since, m_len, m_target, m_tmo_lim;
  bit [7:0] m_pattern;
  bit       m_bits[$];

  function automatic bit pattern_seen();
    int n;
    n = m_bits.size();
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_bits[n - m_len + k] != m_pattern[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit idle, go;
    if (rst) begin
      {m_busy, m_done, m_det, m_tmo, m_err, m_loaded} = '0;
      m_count = 0; m_since = 0; m_len = 0; m_target = 0; m_tmo_lim = 0; m_pattern = '0;
      m_bits.delete();
      return;
    end
    idle  = !m_busy && !m_done;
    m_det = 1'b0;
    go    = bus.start && !bus.abort && ((idle && m_loaded && !m_err) || m_done);
    if (idle && bus.cfg_valid) begin
      m_pattern = bus.cfg_pattern;
      m_len     = int'(bus.cfg_len);
      m_target  = int'(bus.cfg_target);
      m_tmo_lim = int'(bus.cfg_timeout);
      m_loaded  = 1'b1;
      m_err     = (m_len < 1) || (m_len > MAX_LEN);
    end
    if (bus.abort && !idle) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (go) begin
      m_bits.delete();
      m_count = 0; m_since = 0; m_tmo = 1'b0; m_busy = 1'b1; m_done = 1'b0;
    end else if (m_busy) begin
      m_bits.push_back(a);
      if (m_bits.size() > 16) void'(m_bits.pop_front());
      if (pattern_seen()) begin
        m_det = 1'b1;
        if (m_count < 255) m_count++;
        m_since = 0;
        if (m_target != 0 && m_count == m_target) begin m_busy = 1'b0; m_done = 1'b1; end
      end else begin
        m_since++;
        if (m_tmo_lim != 0 && m_since == m_tmo_lim) begin
          m_busy = 1'b0; m_done = 1'b1; m_tmo = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [13:0] obs();
    return {bus.detected, bus.match_count, bus.busy, bus.done, bus.timed_out, bus.cfg_err,
            bus.cfg_ready};
  endfunction

  function automatic logic [13:0] expv();
    return {m_det, 8'(m_count), m_busy, m_done, m_tmo, m_err, !m_busy && !m_done};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] p, input int len, input int tgt, input int tmo);
    bus.cfg_pattern = p;
    bus.cfg_len     = 4'(len);
    bus.cfg_target  = 8'(tgt);
    bus.cfg_timeout = 16'(tmo);
    bus.cfg_valid   = 1'b1;
    tick();
    bus.cfg_valid   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; a = 1'b0;
    bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0; bus.cfg_timeout = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs() !== 14'h0001) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), 14'h0001);
    end
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL reset_model: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_overlap();
    logic [23:0] stream;
    stream = 24'b0011_0101_1001_1001_1010_1000;
    load_cfg(8'b0011_0011, 6, 2, 0);
    pulse_start();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL overlap_start busy: got %b expected 1", bus.busy);
    end
    for (int i = 0; i < 24; i++) begin
      a = stream[23 - i];
      tick();
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL overlap bit %0d: got %h expected %h", i, obs(), expv());
      end
      if (i <= 16) begin
        n_checks++;
        if (bus.detected !== ((i == 12) || (i == 16))) begin
          n_fail++; $display("FAIL overlap_detected bit %0d: got %b", i, bus.detected);
        end
      end
      if (i == 16) begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.match_count !== 8'd2 || bus.timed_out !== 1'b0) begin
          n_fail++;
          $display("FAIL overlap_done: done %b count %0d tmo %b expected 1 2 0",
                   bus.done, bus.match_count, bus.timed_out);
        end
      end
    end
    pulse_abort();
  endtask

  task automatic test_timeout();
    load_cfg(8'b0000_1010, 4, 0, 5);
    pulse_start();
    a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (bus.done !== (i >= 5) || bus.timed_out !== (i >= 5) || bus.detected !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout edge %0d: done %b tmo %b det %b", i, bus.done, bus.timed_out,
                 bus.detected);
      end
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL timeout_model edge %0d: got %h expected %h", i, obs(), expv());
      end
    end
    // Back-to-back restart straight from DONE.
    pulse_start();
    n_checks++;
    if (bus.busy !== 1'b1 || bus.timed_out !== 1'b0 || bus.match_count !== 8'd0) begin
      n_fail++;
      $display("FAIL restart_from_done: busy %b tmo %b count %0d", bus.busy, bus.timed_out,
               bus.match_count);
    end
    pulse_abort();
  endtask

  task automatic test_saturate();
    load_cfg(8'b0000_0000, 4, 0, 0);
    pulse_start();
    a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n_checks++;
      if (bus.detected !== (i >= 3) || obs() !== expv()) begin
        n_fail++; $display("FAIL saturate bit %0d: got %h expected %h", i, obs(), expv());
      end
    end
    n_checks++;
    if (bus.match_count !== 8'd255) begin
      n_fail++; $display("FAIL saturate_count: got %0d expected 255", bus.match_count);
    end
    pulse_abort();
  endtask

  task automatic test_abort();
    logic [23:0] stream;
    stream = 24'b0011_0101_1001_1001_1010_1000;
    load_cfg(8'b0011_0011, 6, 2, 0);
    pulse_start();
    for (int i = 0; i <= 12; i++) begin
      a = stream[23 - i];
      tick();
    end
    pulse_abort();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.match_count !== 8'd1 ||
        bus.cfg_ready !== 1'b1 || bus.detected !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: busy %b done %b count %0d ready %b expected 0 0 1 1",
               bus.busy, bus.done, bus.match_count, bus.cfg_ready);
    end
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || obs() !== expv()) begin
      n_fail++; $display("FAIL start_abort_same: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_cfg_err();
    int bad[2];
    bad[0] = 0; bad[1] = 9;
    foreach (bad[k]) begin
      load_cfg(8'hA5, bad[k], 0, 0);
      n_checks++;
      if (bus.cfg_err !== 1'b1) begin
        n_fail++; $display("FAIL cfg_err len %0d: got %b expected 1", bad[k], bus.cfg_err);
      end
      pulse_start();
      n_checks++;
      if (bus.busy !== 1'b0 || obs() !== expv()) begin
        n_fail++; $display("FAIL cfg_err_start len %0d: got %h expected %h", bad[k], obs(), expv());
      end
    end
    load_cfg(8'b0000_0101, 3, 0, 0);
    pulse_start();
    bus.cfg_valid = 1'b1; bus.cfg_pattern = 8'h00; bus.cfg_len = 4'd1;
    for (int i = 0; i < 40; i++) begin
      a = 1'($urandom);
      tick();
      n_checks++;
      if (bus.cfg_ready !== 1'b0 || obs() !== expv()) begin
        n_fail++; $display("FAIL cfg_in_run cycle %0d: got %h expected %h", i, obs(), expv());
      end
    end
    bus.cfg_valid = 1'b0;
    pulse_abort();
  endtask

  task automatic test_reset_mid_run();
    load_cfg(8'b0000_0010, 2, 0, 0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      a = ~i[0];
      tick();
    end
    n_checks++;
    if (bus.match_count !== 8'd3 || obs() !== expv()) begin
      n_fail++; $display("FAIL pre_reset count: got %0d expected 3", bus.match_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs() !== 14'h0001) begin
      n_fail++; $display("FAIL reset_mid_run: got %h expected %h", obs(), 14'h0001);
    end
    pulse_start();
    n_checks++;
    if (bus.busy !== 1'b0 || obs() !== expv()) begin
      n_fail++; $display("FAIL start_after_reset: busy %b expected 0", bus.busy);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      load_cfg(8'($urandom), $urandom_range(4, 1), $urandom_range(5, 0), $urandom_range(10, 0));
      pulse_start();
      for (int i = 0; i < 60; i++) begin
        a         = 1'($urandom);
        bus.start = ($urandom_range(15, 0) == 0);
        bus.abort = ($urandom_range(31, 0) == 0);
        bus.cfg_valid = ($urandom_range(7, 0) == 0);
        bus.cfg_pattern = 8'($urandom);
        bus.cfg_len     = 4'($urandom_range(9, 0));
        bus.cfg_target  = 8'($urandom_range(5, 0));
        bus.cfg_timeout = 16'($urandom_range(10, 0));
        tick();
        n_checks++;
        if (obs() !== expv()) begin
          n_fail++; $display("FAIL random r%0d c%0d: got %h expected %h", r, i, obs(), expv());
        end
      end
      bus.start = 1'b0; bus.cfg_valid = 1'b0;
      pulse_abort();
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_timeout();
    test_saturate();
    test_abort();
    test_cfg_err();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
